// File: rtl/vector_op_issuer.sv
// rtl/vector_op_issuer.sv - queues host vector ops and issues them one at a time to the coprocessor
module vector_op_issuer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             vsi_clk,
  input  logic             vsi_rst_n,
  input  logic [31:0]      host_op,
  input  logic             host_lmul,
  input  logic             host_sew,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic             drain_req,
  output logic             drain_done,
  output logic [31:0]      vsi_op,
  output logic             vsi_lmul,
  output logic             vsi_sew,
  output logic             vsi_op_valid,
  input  logic             vsi_op_ready,
  input  logic             vsi_cop_idle,
  output logic             ovf_err,
  output logic [CNT_W-1:0] issued_cnt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t          state_q, state_d;
  logic [33:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            drain_pending;
  logic            push, pop, clear_out, handshake, drain_cond, fifo_empty;

  assign fifo_empty   = (count == '0);
  assign host_ready   = (count != FULL) & ~drain_pending;
  assign push         = host_valid & host_ready;
  assign vsi_op_valid = (state_q == ISSUE);
  assign handshake    = vsi_op_valid & vsi_op_ready;
  assign drain_cond   = drain_pending & fifo_empty & ~vsi_op_valid & vsi_cop_idle;

  always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
    if (!vsi_rst_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // Pop decisions use the registered count, so an op pushed this edge is never popped at the same edge.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    clear_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (handshake) begin
          if (!fifo_empty) begin
            pop = 1'b1;
          end else begin
            clear_out = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge vsi_clk) begin
    if (push) mem[wr_ptr] <= {host_op, host_lmul, host_sew};
  end

  always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
    if (!vsi_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
    if (!vsi_rst_n) begin
      vsi_op   <= '0;
      vsi_lmul <= 1'b0;
      vsi_sew  <= 1'b0;
    end else if (pop) begin
      {vsi_op, vsi_lmul, vsi_sew} <= mem[rd_ptr];
    end else if (clear_out) begin
      vsi_op   <= '0;
      vsi_lmul <= 1'b0;
      vsi_sew  <= 1'b0;
    end
  end

  always_ff @(posedge vsi_clk or negedge vsi_rst_n) begin
    if (!vsi_rst_n) begin
      drain_pending <= 1'b0;
      drain_done    <= 1'b0;
      ovf_err       <= 1'b0;
      issued_cnt    <= '0;
    end else begin
      drain_done <= drain_cond;
      if (drain_cond)     drain_pending <= 1'b0;
      else if (drain_req) drain_pending <= 1'b1;
      if (host_valid & ~host_ready) ovf_err <= 1'b1;
      if (handshake) issued_cnt <= issued_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_vector_op_issuer.sv
// tb/tb_vector_op_issuer.sv - scoreboard bench for vector_op_issuer
module tb_vector_op_issuer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] host_op = '0;
  logic        host_lmul = 1'b0, host_sew = 1'b0, host_valid = 1'b0;
  logic        host_ready;
  logic        drain_req = 1'b0, drain_done;
  logic [31:0] vsi_op;
  logic        vsi_lmul, vsi_sew, vsi_op_valid;
  logic        op_ready = 1'b0, cop_idle = 1'b0;
  logic        ovf_err;
  logic [15:0] issued_cnt;

  vector_op_issuer #(.DEPTH(4), .CNT_W(16)) dut (
    .vsi_clk(clk), .vsi_rst_n(rst_n),
    .host_op(host_op), .host_lmul(host_lmul), .host_sew(host_sew),
    .host_valid(host_valid), .host_ready(host_ready),
    .drain_req(drain_req), .drain_done(drain_done),
    .vsi_op(vsi_op), .vsi_lmul(vsi_lmul), .vsi_sew(vsi_sew),
    .vsi_op_valid(vsi_op_valid), .vsi_op_ready(op_ready),
    .vsi_cop_idle(cop_idle), .ovf_err(ovf_err), .issued_cnt(issued_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int dd_pulses = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model plus scoreboard queue: q[0] is the op currently presented.
  int          m_cnt = 0;
  bit          m_valid = 0, m_drain = 0, m_ovf = 0, m_dd = 0;
  logic [15:0] m_issued = '0;
  logic [33:0] q[$];
  bit          m_hs, m_rdy, m_push, m_pop, m_dcond;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0; m_valid = 0; m_drain = 0; m_ovf = 0; m_dd = 0; m_issued = '0;
      q.delete();
    end else begin
      m_hs    = m_valid && op_ready;
      m_rdy   = (m_cnt != 4) && !m_drain;
      m_push  = host_valid && m_rdy;
      m_pop   = (m_cnt != 0) && (!m_valid || m_hs);
      m_dcond = m_drain && (m_cnt == 0) && !m_valid && cop_idle;
      if (m_hs) begin
        void'(q.pop_front());
        m_issued = m_issued + 16'd1;
      end
      if (m_push) q.push_back({host_op, host_lmul, host_sew});
      if (host_valid && !m_rdy) m_ovf = 1;
      m_cnt = m_cnt + int'(m_push) - int'(m_pop);
      if (m_pop) m_valid = 1;
      else if (m_hs) m_valid = 0;
      m_dd = m_dcond;
      if (m_dcond) m_drain = 0;
      else if (drain_req) m_drain = 1;
    end
  end

  always @(negedge clk) begin
    check("valid", {63'd0, vsi_op_valid}, {63'd0, m_valid});
    check("host_ready", {63'd0, host_ready}, {63'd0, (m_cnt != 4) && !m_drain});
    check("ovf_err", {63'd0, ovf_err}, {63'd0, m_ovf});
    check("issued_cnt", {48'd0, issued_cnt}, {48'd0, m_issued});
    check("drain_done", {63'd0, drain_done}, {63'd0, m_dd});
    if (m_valid) begin
      if (q.size() > 0) check("payload", {30'd0, vsi_op, vsi_lmul, vsi_sew}, {30'd0, q[0]});
      else check("scoreboard_empty", 64'd1, 64'd0);
    end else begin
      check("payload_zero", {30'd0, vsi_op, vsi_lmul, vsi_sew}, 64'd0);
    end
    if (drain_done) dd_pulses++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] op, input logic l, input logic s);
    host_op = op; host_lmul = l; host_sew = s; host_valid = 1'b1;
  endtask

  task automatic drain_out(input string name);
    int n = 0;
    op_ready = 1'b1;
    while (m_valid && n < 40) begin tick(); n++; end
    op_ready = 1'b0;
    if (n >= 40) check({name, "_timeout"}, 64'd1, 64'd0);
  endtask

  typedef struct {
    logic [31:0] op;
    logic        lmul;
    logic        sew;
    int          wait_cyc;
    logic [15:0] exp_issued;
  } vec_t;

  vec_t        tbl[6];
  logic [15:0] snap;
  int          n;
  logic [31:0] op_a, op_b;

  initial begin
    tbl[0] = '{32'hDEAD_BEEF, 1'b0, 1'b0, 1, 16'd2};
    tbl[1] = '{32'h0000_0001, 1'b1, 1'b1, 2, 16'd3};
    tbl[2] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 3, 16'd4};
    tbl[3] = '{32'h8000_0000, 1'b1, 1'b0, 1, 16'd5};
    tbl[4] = '{32'h5A5A_A5A5, 1'b1, 1'b1, 2, 16'd6};
    tbl[5] = '{32'h0F0F_F0F0, 1'b0, 1'b0, 4, 16'd7};

    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_ready", {63'd0, host_ready}, 64'd1);
    check("rst_valid", {63'd0, vsi_op_valid}, 64'd0);
    check("rst_cnt", {48'd0, issued_cnt}, 64'd0);

    // Single op latency and hold
    drive(32'h0000_1234, 1'b1, 1'b0);
    tick();
    host_valid = 1'b0;
    check("lat_k", {63'd0, vsi_op_valid}, 64'd0);
    tick();
    check("lat_k1_valid", {63'd0, vsi_op_valid}, 64'd1);
    check("lat_k1_op", {32'd0, vsi_op}, 64'h1234);
    repeat (3) tick();
    check("hold_op", {30'd0, vsi_op, vsi_lmul, vsi_sew}, {30'd0, 32'h0000_1234, 2'b10});
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check("hs_valid_low", {63'd0, vsi_op_valid}, 64'd0);
    check("hs_cnt1", {48'd0, issued_cnt}, 64'd1);

    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].op, tbl[i].lmul, tbl[i].sew);
      tick();
      host_valid = 1'b0;
      repeat (tbl[i].wait_cyc) tick();
      check("tbl_op", {30'd0, vsi_op, vsi_lmul, vsi_sew}, {30'd0, tbl[i].op, tbl[i].lmul, tbl[i].sew});
      op_ready = 1'b1;
      tick();
      op_ready = 1'b0;
      check("tbl_cnt", {48'd0, issued_cnt}, {48'd0, tbl[i].exp_issued});
      check("tbl_idle", {63'd0, vsi_op_valid}, 64'd0);
    end

    // Fill: one in flight plus DEPTH queued, then overflow
    for (int i = 0; i < 4; i++) begin
      drive(32'h100 + 32'(i), 1'b0, 1'b1);
      tick();
    end
    check("fill4_ready", {63'd0, host_ready}, 64'd1);
    drive(32'h104, 1'b1, 1'b1);
    tick();
    check("fill5_ready", {63'd0, host_ready}, 64'd0);
    check("fill5_noovf", {63'd0, ovf_err}, 64'd0);
    drive(32'h105, 1'b0, 1'b0);
    tick();
    host_valid = 1'b0;
    check("ovf_set", {63'd0, ovf_err}, 64'd1);
    drain_out("fill");
    check("fill_cnt", {48'd0, issued_cnt}, 64'd12);

    // Back-to-back issue without a valid gap
    op_a = 32'hAAAA_0001;
    op_b = 32'hBBBB_0002;
    drive(op_a, 1'b0, 1'b0);
    tick();
    drive(op_b, 1'b1, 1'b0);
    tick();
    host_valid = 1'b0;
    check("b2b_a", {32'd0, vsi_op}, {32'd0, op_a});
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check("b2b_nogap", {63'd0, vsi_op_valid}, 64'd1);
    check("b2b_b", {32'd0, vsi_op}, {32'd0, op_b});
    op_ready = 1'b1;
    tick();
    op_ready = 1'b0;
    check("b2b_cnt", {48'd0, issued_cnt}, 64'd14);
    check("b2b_idle", {63'd0, vsi_op_valid}, 64'd0);

    // Drain with host pushes blocked
    dd_pulses = 0;
    drive(32'hC0, 1'b0, 1'b0);
    tick();
    drive(32'hC1, 1'b0, 1'b0);
    tick();
    host_valid = 1'b0;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    drive(32'hC2, 1'b1, 1'b1);
    check("drain_block", {63'd0, host_ready}, 64'd0);
    tick();
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    drain_out("drain");
    repeat (3) tick();
    check("drain_wait_idle", dd_pulses, 64'd0);
    check("drain_still_block", {63'd0, host_ready}, 64'd0);
    host_valid = 1'b0;
    cop_idle = 1'b1;
    repeat (4) tick();
    check("drain_once", dd_pulses, 64'd1);
    check("drain_ready_back", {63'd0, host_ready}, 64'd1);
    check("drain_cnt", {48'd0, issued_cnt}, 64'd16);

    // Reset while issuing with three queued
    for (int i = 0; i < 4; i++) begin
      drive(32'hE0 + 32'(i), 1'b1, 1'b0);
      tick();
    end
    host_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_valid", {63'd0, vsi_op_valid}, 64'd0);
    check("rst_mid_op", {30'd0, vsi_op, vsi_lmul, vsi_sew}, 64'd0);
    check("rst_mid_cnt", {48'd0, issued_cnt}, 64'd0);
    check("rst_mid_ovf", {63'd0, ovf_err}, 64'd0);
    check("rst_mid_ready", {63'd0, host_ready}, 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    op_ready = 1'b1;
    repeat (5) tick();
    op_ready = 1'b0;
    check("rst_no_issue", {63'd0, vsi_op_valid}, 64'd0);
    check("rst_no_cnt", {48'd0, issued_cnt}, 64'd0);

    // Counter wrap with continuous traffic
    op_ready = 1'b1;
    host_valid = 1'b1;
    n = 0;
    while (m_issued != 16'hFFFF && n < 70000) begin
      host_op = $urandom;
      host_lmul = 1'($urandom);
      host_sew = 1'($urandom);
      tick();
      n++;
    end
    if (n >= 70000) check("wrap_timeout", 64'd1, 64'd0);
    check("wrap_max", {48'd0, issued_cnt}, 64'hFFFF);
    snap = m_issued;
    n = 0;
    while (m_issued == snap && n < 10) begin tick(); n++; end
    check("wrap_zero", {48'd0, issued_cnt}, 64'h0000);
    host_valid = 1'b0;
    drain_out("wrap");
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_op_issuer.md
VECTOR_OP_ISSUER -- requirements
Module: vector_op_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning op FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter CNT_W, default 16, meaning width of issued-op counter.
REQ-003 vsi_clk  input  1  clock, all state on rising edge.
REQ-004 vsi_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 host_op  input  32  vector instruction from scalar core.
REQ-006 host_lmul  input  1  LMUL attribute travelling with host_op.
REQ-007 host_sew  input  1  SEW attribute travelling with host_op.
REQ-008 host_valid  input  1  host push request.
REQ-009 host_ready  output  1  FIFO can accept; push = host_valid & host_ready.
REQ-010 drain_req  input  1  single-cycle pulse requesting full drain.
REQ-011 drain_done  output  1  single-cycle pulse, drain complete.
REQ-012 vsi_op  output  32  op to coprocessor.
REQ-013 vsi_lmul  output  1  LMUL to coprocessor.
REQ-014 vsi_sew  output  1  SEW to coprocessor.
REQ-015 vsi_op_valid  output  1  op presented to coprocessor.
REQ-016 vsi_op_ready  input  1  coprocessor completion/accept.
REQ-017 vsi_cop_idle  input  1  coprocessor idle.
REQ-018 ovf_err  output  1  sticky: push attempted while host_ready=0.
REQ-019 issued_cnt  output  CNT_W  completed handshakes, wraps modulo 2^CNT_W.

Function
REQ-020 SHALL store {host_op, host_lmul, host_sew} (34 bits) in a DEPTH-entry circular FIFO with wrapping read/write pointers and occupancy count 0..DEPTH.
REQ-021 host_ready SHALL equal (count != DEPTH) & !drain_pending; a pop in the same cycle SHALL NOT make a full FIFO accept.
REQ-022 host_valid & !host_ready SHALL drop the op, leave FIFO unchanged, and set ovf_err until reset.
REQ-023 FSM states SHALL be IDLE (vsi_op_valid=0) and ISSUE (vsi_op_valid=1); vsi_op/vsi_lmul/vsi_sew/vsi_op_valid SHALL be driven from registers.
REQ-024 IDLE->ISSUE when count!=0: pop head into output registers at the same edge.
REQ-025 Handshake SHALL be vsi_op_valid & vsi_op_ready in the same cycle; vsi_op_ready while vsi_op_valid=0 SHALL be ignored.
REQ-026 In ISSUE, output registers and vsi_op_valid SHALL hold stable every cycle until handshake (coprocessor uses vsi_op throughout execution).
REQ-027 On handshake: if count!=0, pop next entry into output registers and stay ISSUE (back-to-back, no bubble); else go IDLE, vsi_op_valid=0 next cycle.
REQ-028 Latency: op pushed at edge k into empty FIFO with FSM in IDLE SHALL give vsi_op_valid=1 from edge k+1.
REQ-029 Simultaneous push and pop SHALL keep count unchanged; push into empty FIFO SHALL not be popped at that same edge.
REQ-030 issued_cnt SHALL increment by 1 on each handshake; 2^CNT_W-1 wraps to 0.
REQ-031 drain_req SHALL set drain_pending (repeat pulses while pending have no effect).
REQ-032 drain_done SHALL pulse 1 cycle at the edge after a cycle where drain_pending & count==0 & !vsi_op_valid & vsi_cop_idle; drain_pending clears at that same edge.
REQ-033 Ops in FIFO SHALL continue to issue during drain; only host pushes are blocked.
REQ-034 Output payload registers SHALL be 0 whenever vsi_op_valid=0 after reset or handshake-to-IDLE.

Reset
REQ-035 On vsi_rst_n=0, asynchronously: FIFO empty, pointers 0, FSM IDLE, vsi_op=0, vsi_lmul=0, vsi_sew=0, vsi_op_valid=0, drain_pending=0, drain_done=0, ovf_err=0, issued_cnt=0; host_ready=1 after release.
REQ-036 Reset mid-ISSUE SHALL drop presented and queued ops with no handshake counted.

Verification
REQ-037 Push op 0x0000_1234 (lmul=1,sew=0) at edge k, ready low -> vsi_op=0x0000_1234, valid=1 from k+1, held stable; ready pulse at k+5 -> valid=0 after k+5, issued_cnt=1.
REQ-038 Push 4 ops back-to-back, ready held low -> host_ready=0 after 4th push with 1 in flight? No: count reaches 3 (one popped); 5th push accepted, 6th -> host_ready=0; push while full -> dropped, ovf_err=1.
REQ-039 Queue A,B; ready high one cycle per op -> B presented the edge A handshakes, no valid gap; issued_cnt=2.
REQ-040 Two ops queued, drain_req pulse, host_valid held -> host_ready=0; after both handshake and vsi_cop_idle=1, drain_done pulses exactly once; host_ready returns 1.
REQ-041 Assert vsi_rst_n=0 mid-ISSUE with 3 queued -> all outputs reset immediately; after release no op issued.
REQ-042 Preload issued_cnt path to 0xFFFF with 65535 handshakes (or force) plus one more -> issued_cnt=0x0000.
